fc_layer_engine: RTL

FC_LAYER_ENGINE -- requirements
Module: fc_layer_engine

---
 rtl/fc_pkg.sv | 25 ++
 rtl/fc_requant.sv | 26 ++
 rtl/fc_layer_engine.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer engine: default geometry,
// FSM state encoding and the address-width helper.
package fc_pkg;

  localparam int FC_IN_LEN  = 84;
  localparam int FC_OUT_LEN = 10;
  localparam int FC_DATA_W  = 8;
  localparam int FC_ACC_W   = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BIAS_RD = 3'd1,
    BIAS_LD = 3'd2,
    MAC     = 3'd3,
    DRAIN   = 3'd4,
    WRITE   = 3'd5,
    FIN     = 3'd6
  } fc_state_e;

  // Address width that stays at least 1 bit, so a length of 1 still yields a legal port.
  function automatic int fc_clog2(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/fc_requant.sv
// Combinational ReLU + arithmetic right shift + clamp to the positive signed
// DATA_W range, zero-extended back to ACC_W.
module fc_requant
  import fc_pkg::*;
#(
  parameter int DATA_W = FC_DATA_W,
  parameter int ACC_W  = FC_ACC_W
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic        [4:0]       shift,
  output logic        [ACC_W-1:0] q
);

  localparam logic [ACC_W-1:0] QMAX = ACC_W'((1 << (DATA_W - 1)) - 1);

  logic [ACC_W-1:0] pos;
  logic [ACC_W-1:0] shifted;

  // Once negatives are zeroed the value is non-negative, so a logical shift equals >>>.
  always_comb begin
    pos     = acc[ACC_W-1] ? '0 : acc;
    shifted = pos >> shift;
    q       = (shifted > QMAX) ? QMAX : shifted;
  end

endmodule

// File: rtl/fc_layer_engine.sv
// Sequential fully-connected layer: one MAC per cycle over IN_LEN inputs for each
// of OUT_LEN neurons. Define FC_ARGMAX_EN to add argmax_idx/argmax_val outputs.
//
//   state   | meaning
//   IDLE    | waiting for start
//   BIAS_RD | bias address presented for the current neuron
//   BIAS_LD | acc <= bias, input/weight index 0 presented
//   MAC     | one address pair per cycle, previous product accumulated
//   DRAIN   | last product accumulated
//   WRITE   | out_we pulse for the current neuron
//   FIN     | last neuron written, done pulses on the following cycle
module fc_layer_engine
  import fc_pkg::*;
#(
  parameter int IN_LEN  = FC_IN_LEN,
  parameter int OUT_LEN = FC_OUT_LEN,
  parameter int DATA_W  = FC_DATA_W,
  parameter int ACC_W   = FC_ACC_W
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  output logic                                   busy,
  output logic                                   done,
  input  logic                                   relu_en,
  input  logic        [4:0]                      shift,
  output logic        [fc_clog2(IN_LEN)-1:0]         in_addr,
  input  logic signed [DATA_W-1:0]               in_data,
  output logic        [fc_clog2(IN_LEN*OUT_LEN)-1:0] w_addr,
  input  logic signed [DATA_W-1:0]               w_data,
  output logic        [fc_clog2(OUT_LEN)-1:0]        b_addr,
  input  logic signed [ACC_W-1:0]                b_data,
  output logic                                   out_we,
  output logic        [fc_clog2(OUT_LEN)-1:0]        out_addr,
  output logic        [ACC_W-1:0]                out_data
`ifdef FC_ARGMAX_EN
  ,
  output logic        [fc_clog2(OUT_LEN)-1:0]        argmax_idx,
  output logic        [ACC_W-1:0]                argmax_val
`endif
);

  localparam int IA_W = fc_clog2(IN_LEN);
  localparam int WA_W = fc_clog2(IN_LEN * OUT_LEN);
  localparam int NA_W = fc_clog2(OUT_LEN);

  localparam logic [IA_W-1:0] IN_LAST  = IA_W'(IN_LEN - 1);
  localparam logic [NA_W-1:0] NEU_LAST = NA_W'(OUT_LEN - 1);
  localparam logic [WA_W-1:0] W_STEP   = WA_W'(IN_LEN);

  fc_state_e state, state_nx;

  logic        [NA_W-1:0]     neu_idx;
  logic        [IA_W-1:0]     in_idx;
  logic        [WA_W-1:0]     w_base;
  logic signed [ACC_W-1:0]    acc;
  logic                       relu_q;
  logic        [4:0]          shift_q;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic        [ACC_W-1:0]    q_relu;

  assign prod     = in_data * w_data;
  assign prod_ext = ACC_W'(prod);

  fc_requant #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_requant (
    .acc  (acc),
    .shift(shift_q),
    .q    (q_relu)
  );

  assign in_addr  = in_idx;
  assign w_addr   = w_base + WA_W'(in_idx);
  assign b_addr   = neu_idx;
  assign busy     = (state != IDLE);
  assign out_we   = (state == WRITE);
  assign out_addr = neu_idx;
  assign out_data = out_we ? (relu_q ? q_relu : acc) : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = BIAS_RD;
      BIAS_RD: state_nx = BIAS_LD;
      BIAS_LD: state_nx = MAC;
      MAC:     if (in_idx == IN_LAST) state_nx = DRAIN;
      DRAIN:   state_nx = WRITE;
      WRITE:   state_nx = (neu_idx == NEU_LAST) ? FIN : BIAS_RD;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The product seen in MAC cycle 0 belongs to the BIAS_LD address, which MAC cycle 0
  // re-issues, so accumulation starts at index 1 and DRAIN picks up the final product.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      neu_idx <= '0;
      in_idx  <= '0;
      w_base  <= '0;
      relu_q  <= 1'b0;
      shift_q <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == FIN);
      case (state)
        IDLE: begin
          if (start) begin
            neu_idx <= '0;
            in_idx  <= '0;
            w_base  <= '0;
            relu_q  <= relu_en;
            shift_q <= shift;
          end
        end
        BIAS_LD: acc <= b_data;
        MAC: begin
          if (in_idx != '0)      acc    <= acc + prod_ext;
          if (in_idx != IN_LAST) in_idx <= in_idx + IA_W'(1);
        end
        DRAIN: begin
          acc    <= acc + prod_ext;
          in_idx <= '0;
        end
        WRITE: begin
          if (neu_idx != NEU_LAST) begin
            neu_idx <= neu_idx + NA_W'(1);
            w_base  <= w_base + W_STEP;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FC_ARGMAX_EN
  logic am_have;

  // Strict greater-than keeps the earliest (lowest) index on ties.
  always_ff @(posedge clk) begin
    if (rst) begin
      am_have    <= 1'b0;
      argmax_idx <= '0;
      argmax_val <= '0;
    end else if (state == IDLE && start) begin
      am_have    <= 1'b0;
      argmax_idx <= '0;
      argmax_val <= '0;
    end else if (out_we && (!am_have || $signed(out_data) > $signed(argmax_val))) begin
      am_have    <= 1'b1;
      argmax_idx <= out_addr;
      argmax_val <= out_data;
    end
  end
`endif

endmodule
